// File: rtl/rgb_led_pkg.sv
// Shared types for the RGB LED PWM driver: channel modes and the default-width
// channel configuration record.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_t;

    localparam int unsigned LED_PWM_W_DEF = 8;

    // Default-width channel record; channels build the same layout at their
    // own PWM_W.
    typedef struct packed {
        led_mode_t                mode;
        logic [LED_PWM_W_DEF-1:0] duty;
    } led_cfg_t;

endpackage

// File: rtl/rgb_led_pwm_ch.sv
// One LED channel: shadow/active configuration, level select and the
// registered PWM compare. Optional breathe support is controlled by the
// macro RGB_LED_PWM_BREATHE_EN (undefined: BREATHE acts as ON).
module rgb_led_pwm_ch
    import rgb_led_pkg::*;
#(
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  led_mode_t        mode_i,
    input  logic [PWM_W-1:0] duty_i,
    input  logic             frame_i,     // high in the cycle whose edge wraps the PWM counter
    input  logic             blink_ph_i,
`ifdef RGB_LED_PWM_BREATHE_EN
    input  logic [PWM_W-1:0] ramp_i,
`endif
    input  logic [PWM_W-1:0] pwm_cnt_i,
    output logic             led_o
);

    typedef struct packed {
        led_mode_t        mode;
        logic [PWM_W-1:0] duty;
    } ch_cfg_t;

    ch_cfg_t          wr_cfg;
    ch_cfg_t          shadow_q, shadow_d;
    ch_cfg_t          active_q, active_d;
    logic [PWM_W-1:0] level;
    logic             led_q, led_d;

`ifdef RGB_LED_PWM_BREATHE_EN
    function automatic logic [PWM_W-1:0] level_min(input logic [PWM_W-1:0] a,
                                                   input logic [PWM_W-1:0] b);
        return (a < b) ? a : b;
    endfunction
`endif

    // Shadow captures every write; active reloads only at the frame wrap, and a
    // write landing on that same edge goes straight through.
    always_comb begin
        wr_cfg   = '{mode: mode_i, duty: duty_i};
        shadow_d = wr_i ? wr_cfg : shadow_q;
        active_d = active_q;
        if (frame_i) begin
            active_d = wr_i ? wr_cfg : shadow_q;
        end
    end

    // Level selection from the active mode, then the unsigned PWM compare.
    always_comb begin
        level = '0;
        case (active_q.mode)
            LED_OFF:     level = '0;
            LED_ON:      level = active_q.duty;
            LED_BLINK:   level = blink_ph_i ? active_q.duty : '0;
`ifdef RGB_LED_PWM_BREATHE_EN
            LED_BREATHE: level = level_min(ramp_i, active_q.duty);
`else
            LED_BREATHE: level = active_q.duty;
`endif
            default:     level = '0;
        endcase
        led_d = (pwm_cnt_i < level);
    end

    // Configuration and output registers; reset drops any pending write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '{mode: LED_OFF, duty: '0};
            active_q <= '{mode: LED_OFF, duty: '0};
            led_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/rgb_led_pwm.sv
// Multi-channel LED PWM driver: shared prescaler, PWM counter, blink phase
// and breathe ramp feeding N_CH channel instances. Breathe ramp is built only
// when RGB_LED_PWM_BREATHE_EN is defined.
module rgb_led_pwm
    import rgb_led_pkg::*;
#(
    parameter int unsigned N_CH         = 6,
    parameter int unsigned PWM_W        = 8,
    parameter int unsigned PRESCALE     = 16,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cfg_wr,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [1:0]              cfg_mode,
    input  logic [PWM_W-1:0]        cfg_duty,
    output logic [N_CH-1:0]         led_o,
    output logic                    frame_o
);

    localparam int unsigned CH_W    = $clog2(N_CH);
    localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BF_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]   pwm_q, pwm_d;
    logic [BF_W-1:0]    bcnt_q, bcnt_d;
    logic               blink_ph_q, blink_ph_d;
    logic               frame_q, frame_d;
    logic               tick;
    logic               wrap;

    // Prescaler, PWM counter and blink phase; everything frame-based moves on wrap.
    always_comb begin
        tick       = (presc_q == PRESC_W'(PRESCALE - 1));
        wrap       = tick && (pwm_q == '1);
        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_d      = tick ? pwm_q + PWM_W'(1) : pwm_q;
        frame_d    = wrap;
        bcnt_d     = bcnt_q;
        blink_ph_d = blink_ph_q;
        if (wrap) begin
            if (bcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                bcnt_d     = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                bcnt_d = bcnt_q + BF_W'(1);
            end
        end
    end

    // Shared timebase registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            presc_q    <= '0;
            pwm_q      <= '0;
            bcnt_q     <= '0;
            blink_ph_q <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            pwm_q      <= pwm_d;
            bcnt_q     <= bcnt_d;
            blink_ph_q <= blink_ph_d;
            frame_q    <= frame_d;
        end
    end

`ifdef RGB_LED_PWM_BREATHE_EN
    logic [PWM_W-1:0] ramp_q, ramp_d;
    logic             ramp_up_q, ramp_up_d;

    // Triangle ramp: one step per frame, end values held for a frame while the
    // direction flips.
    always_comb begin
        ramp_d    = ramp_q;
        ramp_up_d = ramp_up_q;
        if (wrap) begin
            if (ramp_up_q) begin
                if (ramp_q == '1) ramp_up_d = 1'b0;
                else              ramp_d    = ramp_q + PWM_W'(1);
            end else begin
                if (ramp_q == '0) ramp_up_d = 1'b1;
                else              ramp_d    = ramp_q - PWM_W'(1);
            end
        end
    end

    // Ramp registers, starting at 0 counting up.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ramp_q    <= '0;
            ramp_up_q <= 1'b1;
        end else begin
            ramp_q    <= ramp_d;
            ramp_up_q <= ramp_up_d;
        end
    end
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        rgb_led_pwm_ch #(
            .PWM_W(PWM_W)
        ) u_ch (
            .clk_i      (aclk),
            .rst_i      (areset),
            .wr_i       (cfg_wr && (cfg_ch == CH_W'(i))),
            .mode_i     (led_mode_t'(cfg_mode)),
            .duty_i     (cfg_duty),
            .frame_i    (wrap),
            .blink_ph_i (blink_ph_q),
`ifdef RGB_LED_PWM_BREATHE_EN
            .ramp_i     (ramp_q),
`endif
            .pwm_cnt_i  (pwm_q),
            .led_o      (led_o[i])
        );
    end

    assign frame_o = frame_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Self-checking bench for rgb_led_pwm. The reference model works from the
// cycle count since reset: PWM value, frame index, blink phase and ramp are
// closed-form, and each channel's config for a frame is the last write sampled
// at or before that frame's starting edge.
`timescale 1ns/1ps
module tb_rgb_led_pwm;

    localparam int N_CH         = 6;
    localparam int PWM_W        = 4;
    localparam int PRESCALE     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int STEPS        = 1 << PWM_W;
    localparam int MAXV         = STEPS - 1;
    localparam int FRAME        = PRESCALE * STEPS;

    logic            aclk     = 1'b0;
    logic            areset   = 1'b1;
    logic            cfg_wr   = 1'b0;
    logic [2:0]      cfg_ch   = '0;
    logic [1:0]      cfg_mode = '0;
    logic [3:0]      cfg_duty = '0;
    logic [N_CH-1:0] led_o;
    logic            frame_o;

    int total = 0;
    int bad   = 0;
    int t     = 0;   // edges since the last reset edge

    int q_edge[$];
    int q_ch[$];
    int q_mode[$];
    int q_duty[$];

    rgb_led_pwm #(
        .N_CH        (N_CH),
        .PWM_W       (PWM_W),
        .PRESCALE    (PRESCALE),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty),
        .led_o   (led_o),
        .frame_o (frame_o)
    );

    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic int ramp_at(input int f);
        int q;
        q = f % (2 * STEPS);
        return (q <= MAXV) ? q : (2 * MAXV + 1) - q;
    endfunction

    function automatic logic exp_led(input int c);
        int s, f, p, lvl, m, d;
        if (t == 0) return 1'b0;
        s = t - 1;
        f = s / FRAME;
        p = (s / PRESCALE) % STEPS;
        m = 0;
        d = 0;
        foreach (q_edge[k]) begin
            if (q_ch[k] == c && q_edge[k] <= f * FRAME) begin
                m = q_mode[k];
                d = q_duty[k];
            end
        end
        case (m)
            1:       lvl = d;
            2:       lvl = (((f / BLINK_FRAMES) % 2) == 1) ? d : 0;
`ifdef RGB_LED_PWM_BREATHE_EN
            3:       lvl = (ramp_at(f) < d) ? ramp_at(f) : d;
`else
            3:       lvl = d;
`endif
            default: lvl = 0;
        endcase
        return (p < lvl);
    endfunction

    // Drive one cycle of inputs, let the edge happen, update the model, check.
    task automatic cyc(input logic wr, input int ch, input int mode, input int duty);
        logic fexp;
        cfg_wr   = wr;
        cfg_ch   = 3'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = 4'(duty);
        @(posedge aclk);
        if (areset) begin
            t = 0;
            q_edge.delete();
            q_ch.delete();
            q_mode.delete();
            q_duty.delete();
        end else begin
            t++;
            if (wr && ch < N_CH) begin
                q_edge.push_back(t);
                q_ch.push_back(ch);
                q_mode.push_back(mode);
                q_duty.push_back(duty);
            end
        end
        @(negedge aclk);
        cfg_wr = 1'b0;
        fexp = (t > 0) && ((t % FRAME) == 0);
        check_val("frame_o", 32'(frame_o), 32'(fexp));
        for (int c = 0; c < N_CH; c++) begin
            check_val($sformatf("led_o[%0d]", c), 32'(led_o[c]), 32'(exp_led(c)));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0);
    endtask

    initial begin
        @(negedge aclk);
        areset = 1'b1;
        idle(3);
        areset = 1'b0;

        // quiet run: no LEDs, frame pulses at 32/64/96
        idle(100);

        // ch0 ON at duty 4, 0 and full scale
        cyc(1'b1, 0, 1, 4);
        idle(2 * FRAME);
        cyc(1'b1, 0, 1, 0);
        idle(2 * FRAME);
        cyc(1'b1, 0, 1, 15);
        idle(2 * FRAME);

        // ch1 BLINK at duty 8
        cyc(1'b1, 1, 2, 8);
        idle(6 * FRAME);

        // ch2: write on the wrap edge, then one edge after it
        while (((t + 1) % FRAME) != 0) idle(1);
        cyc(1'b1, 2, 1, 8);
        while (((t + 1) % FRAME) != 1) idle(1);
        cyc(1'b1, 2, 1, 3);
        idle(2 * FRAME);

        // ch3 BREATHE at duty 6 through a full ramp cycle
        cyc(1'b1, 3, 3, 6);
        idle(34 * FRAME);

        // randomized writes, including out-of-range channels and same-frame rewrites
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0)
                cyc(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 15)));
            else
                idle(1);
        end

        // all channels active, pending shadow write, then reset mid-frame
        for (int c = 0; c < N_CH; c++) cyc(1'b1, c, int'($urandom_range(1, 3)), int'($urandom_range(1, 15)));
        idle(2 * FRAME);
        while ((t % FRAME) != 10) idle(1);
        cyc(1'b1, 4, 1, 15);
        areset = 1'b1;
        cyc(1'b1, 5, 1, 9);
        areset = 1'b0;
        cyc(1'b1, 6, 1, 9);
        cyc(1'b1, 7, 2, 12);
        idle(3 * FRAME);

        // second randomized run after reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                cyc(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 15)));
            else
                idle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
